dual_beam_thresh_servo: RTL and testbench

- Sits directly upstream of the dual-beam trigger stage. Drives its thresh_i, thresh_ce_i and update_i ports, and consumes its trigger_o[1:0].
- Counts triggers per beam over a fixed gate period and compares each count with a target rate.
- Steps each beam threshold up or down by a programmable step, then replays the three-cycle threshold load protocol.
- Software can also write thresholds directly. Direct writes use the same load sequence.

---
 rtl/dual_beam_pkg.sv | 22 ++
 rtl/dual_beam_thresh_servo_counter.sv | 43 ++++
 rtl/dual_beam_thresh_servo.sv | 183 ++++++++++++++++++
 tb/tb_dual_beam_thresh_servo.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_beam_pkg.sv
// Shared definitions for the dual-beam threshold servo: widths, beam indices,
// load-sequence states and the chip-enable encodings seen by the trigger stage.
package dual_beam_pkg;

  localparam int unsigned THRESH_BITS = 18;
  localparam int unsigned MAX_THRESH  = 246016;

  localparam int unsigned BEAM_A = 1;
  localparam int unsigned BEAM_B = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    UPDATE = 2'd3
  } load_state_t;

  localparam logic [1:0] CE_A    = 2'b10;
  localparam logic [1:0] CE_B    = 2'b01;
  localparam logic [1:0] CE_NONE = 2'b00;

endpackage

// File: rtl/dual_beam_thresh_servo_counter.sv
// Per-beam saturating trigger counter; latches its final value at period end
// and restarts so the next period counts from the following cycle.
module beam_rate_counter
  import dual_beam_pkg::*;
#(
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                trigger_i,
  input  logic                period_end_i,
  output logic [CNT_BITS-1:0] count_o,
  output logic [CNT_BITS-1:0] final_o
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [CNT_BITS-1:0] acc_q;
  logic [CNT_BITS-1:0] acc_inc;

  // final_o includes the trigger present in the current cycle.
  always_comb begin
    acc_inc = acc_q;
    if (trigger_i && (acc_q != CNT_MAX)) acc_inc = acc_q + 1'b1;
  end

  assign final_o = acc_inc;

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      count_o <= '0;
    end else if (period_end_i) begin
      acc_q   <= '0;
      count_o <= acc_inc;
    end else begin
      acc_q   <= acc_inc;
    end
  end

endmodule

// File: rtl/dual_beam_thresh_servo.sv
// Closed-loop threshold servo for the dual-beam trigger stage: measures trigger
// rates per gate period, nudges each threshold and replays the load protocol.
module dual_beam_thresh_servo #(
  parameter int unsigned THRESH_BITS = dual_beam_pkg::THRESH_BITS,
  parameter int unsigned CNT_BITS    = 16,
  parameter int unsigned PERIOD      = 1048576,
  parameter int unsigned MAX_THRESH  = dual_beam_pkg::MAX_THRESH,
  parameter int unsigned INIT_THRESH = 246016
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             trigger_i,
  input  logic                   en_i,
  input  logic [CNT_BITS-1:0]    target_i,
  input  logic [7:0]             step_i,
  input  logic                   thresh_wr_i,
  input  logic                   thresh_sel_i,
  input  logic [THRESH_BITS-1:0] thresh_wdata_i,
  output logic [THRESH_BITS-1:0] thresh_o,
  output logic [1:0]             thresh_ce_o,
  output logic                   update_o,
  output logic [THRESH_BITS-1:0] thresh_a_o,
  output logic [THRESH_BITS-1:0] thresh_b_o,
  output logic [CNT_BITS-1:0]    count_a_o,
  output logic [CNT_BITS-1:0]    count_b_o,
  output logic                   count_valid_o,
  output logic                   busy_o
);

  import dual_beam_pkg::*;

  localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [THRESH_BITS-1:0] MAX_T  = THRESH_BITS'(MAX_THRESH);
  localparam logic [THRESH_BITS-1:0] INIT_T = THRESH_BITS'(INIT_THRESH);
  localparam logic [THRESH_BITS:0]   MAX_W  = (THRESH_BITS+1)'(MAX_THRESH);

  // Saturating step toward the target rate; higher count means raise threshold.
  function automatic logic [THRESH_BITS-1:0] servo_next(
    input logic [THRESH_BITS-1:0] th,
    input logic [CNT_BITS-1:0]    cnt,
    input logic [CNT_BITS-1:0]    tgt,
    input logic [7:0]             step
  );
    logic [THRESH_BITS-1:0] step_ext;
    logic [THRESH_BITS:0]   sum;
    step_ext = {{(THRESH_BITS-8){1'b0}}, step};
    sum      = {1'b0, th} + {1'b0, step_ext};
    if (cnt > tgt)      return (sum > MAX_W) ? MAX_T : sum[THRESH_BITS-1:0];
    else if (cnt < tgt) return (th < step_ext) ? '0 : th - step_ext;
    else                return th;
  endfunction

  logic [PW-1:0]          period_q;
  logic                   period_end;
  logic [CNT_BITS-1:0]    final_a, final_b;
  logic [THRESH_BITS-1:0] thresh_a_q, thresh_b_q, thresh_a_d, thresh_b_d;
  logic [THRESH_BITS-1:0] wdata_clamped;
  logic                   pend_set, pending_q, pending_d;
  load_state_t            state_q, state_d;
  logic [THRESH_BITS-1:0] thresh_d;
  logic [1:0]             ce_d;
  logic                   update_d, busy_d;

  assign period_end = (period_q == PW'(PERIOD - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      period_q      <= '0;
      count_valid_o <= 1'b0;
    end else begin
      period_q      <= period_end ? '0 : period_q + 1'b1;
      count_valid_o <= period_end;
    end
  end

  beam_rate_counter #(.CNT_BITS(CNT_BITS)) u_cnt_a (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .trigger_i    (trigger_i[BEAM_A]),
    .period_end_i (period_end),
    .count_o      (count_a_o),
    .final_o      (final_a)
  );

  beam_rate_counter #(.CNT_BITS(CNT_BITS)) u_cnt_b (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .trigger_i    (trigger_i[BEAM_B]),
    .period_end_i (period_end),
    .count_o      (count_b_o),
    .final_o      (final_b)
  );

  assign wdata_clamped = (thresh_wdata_i > MAX_T) ? MAX_T : thresh_wdata_i;

  // Direct write is applied last so it overrides a coincident servo step.
  // NOTE: every combinational output gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    thresh_a_d = thresh_a_q;
    thresh_b_d = thresh_b_q;
    if (period_end && en_i) begin
      thresh_a_d = servo_next(thresh_a_q, final_a, target_i, step_i);
      thresh_b_d = servo_next(thresh_b_q, final_b, target_i, step_i);
    end
    if (thresh_wr_i) begin
      if (thresh_sel_i) thresh_a_d = wdata_clamped;
      else              thresh_b_d = wdata_clamped;
    end
  end

  assign pend_set = thresh_wr_i || (thresh_a_d != thresh_a_q) || (thresh_b_d != thresh_b_q);

  // A set arriving on the same edge as the IDLE->LOAD_A clear is retained.
  always_comb begin
    pending_d = pending_q;
    if (state_q == IDLE && pending_q) pending_d = 1'b0;
    if (pend_set)                     pending_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pending_q) state_d = LOAD_A;
      LOAD_A:  state_d = LOAD_B;
      LOAD_B:  state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the next state so they are registered alongside it.
  always_comb begin
    thresh_d = thresh_o;
    ce_d     = CE_NONE;
    update_d = 1'b0;
    unique case (state_d)
      LOAD_A: begin
        thresh_d = thresh_a_q;
        ce_d     = CE_A;
      end
      LOAD_B: begin
        thresh_d = thresh_b_q;
        ce_d     = CE_B;
      end
      UPDATE:  update_d = 1'b1;
      default: ;
    endcase
    busy_d = (state_d != IDLE) || pending_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pending_q  <= 1'b1;
      thresh_a_q <= INIT_T;
      thresh_b_q <= INIT_T;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      thresh_a_q <= thresh_a_d;
      thresh_b_q <= thresh_b_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      thresh_o    <= '0;
      thresh_ce_o <= CE_NONE;
      update_o    <= 1'b0;
      busy_o      <= 1'b1;
    end else begin
      thresh_o    <= thresh_d;
      thresh_ce_o <= ce_d;
      update_o    <= update_d;
      busy_o      <= busy_d;
    end
  end

  assign thresh_a_o = thresh_a_q;
  assign thresh_b_o = thresh_b_q;

endmodule

// File: tb/tb_dual_beam_thresh_servo.sv
// Directed bench for dual_beam_thresh_servo: load timing, servo steps,
// saturation, enable gating, write/adjust collisions and mid-sequence reset.
module tb_dual_beam_thresh_servo;

  localparam int INIT = 246016;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  trigger_i = '0;
  logic        en_i = 1'b1;
  logic [15:0] target_i = 16'd10;
  logic [7:0]  step_i = 8'd4;
  logic        thresh_wr_i = 1'b0;
  logic        thresh_sel_i = 1'b0;
  logic [17:0] thresh_wdata_i = '0;
  logic [17:0] thresh_o, thresh_a_o, thresh_b_o;
  logic [1:0]  thresh_ce_o;
  logic        update_o, count_valid_o, busy_o;
  logic [15:0] count_a_o, count_b_o;

  logic [1:0]  d4_trigger = 2'b11;
  logic [17:0] d4_thresh, d4_thresh_a, d4_thresh_b;
  logic [1:0]  d4_ce;
  logic        d4_update, d4_valid, d4_busy;
  logic [3:0]  d4_count_a, d4_count_b;

  int n_cmp = 0;
  int n_fail = 0;
  int edge_n = 0;

  always #5 clk_i = ~clk_i;

  dual_beam_thresh_servo #(
    .THRESH_BITS(18), .CNT_BITS(16), .PERIOD(64), .MAX_THRESH(246016), .INIT_THRESH(INIT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .trigger_i(trigger_i), .en_i(en_i),
    .target_i(target_i), .step_i(step_i), .thresh_wr_i(thresh_wr_i),
    .thresh_sel_i(thresh_sel_i), .thresh_wdata_i(thresh_wdata_i),
    .thresh_o(thresh_o), .thresh_ce_o(thresh_ce_o), .update_o(update_o),
    .thresh_a_o(thresh_a_o), .thresh_b_o(thresh_b_o),
    .count_a_o(count_a_o), .count_b_o(count_b_o),
    .count_valid_o(count_valid_o), .busy_o(busy_o)
  );

  dual_beam_thresh_servo #(
    .THRESH_BITS(18), .CNT_BITS(4), .PERIOD(32), .MAX_THRESH(246016), .INIT_THRESH(INIT)
  ) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .trigger_i(d4_trigger), .en_i(1'b0),
    .target_i(4'd0), .step_i(8'd0), .thresh_wr_i(1'b0),
    .thresh_sel_i(1'b0), .thresh_wdata_i(18'd0),
    .thresh_o(d4_thresh), .thresh_ce_o(d4_ce), .update_o(d4_update),
    .thresh_a_o(d4_thresh_a), .thresh_b_o(d4_thresh_b),
    .count_a_o(d4_count_a), .count_b_o(d4_count_b),
    .count_valid_o(d4_valid), .busy_o(d4_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    edge_n++;
    #1;
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) tick();
  endtask

  task automatic write_thr(input logic sel, input logic [17:0] val);
    thresh_wr_i    = 1'b1;
    thresh_sel_i   = sel;
    thresh_wdata_i = val;
    tick();
    thresh_wr_i    = 1'b0;
  endtask

  initial begin
    // Reset values while reset is held.
    repeat (2) @(posedge clk_i);
    #1;
    check("rst thresh_o",   32'(thresh_o), 0);
    check("rst ce",         32'(thresh_ce_o), 0);
    check("rst update",     32'(update_o), 0);
    check("rst thresh_a",   32'(thresh_a_o), INIT);
    check("rst thresh_b",   32'(thresh_b_o), INIT);
    check("rst count_a",    32'(count_a_o), 0);
    check("rst valid",      32'(count_valid_o), 0);
    @(negedge clk_i);
    rst_i  = 1'b0;
    edge_n = 0;

    // Automatic load sequence after reset release.
    tick();
    check("boot LOAD_A thresh", 32'(thresh_o), INIT);
    check("boot LOAD_A ce",     32'(thresh_ce_o), 2);
    tick();
    check("boot LOAD_B thresh", 32'(thresh_o), INIT);
    check("boot LOAD_B ce",     32'(thresh_ce_o), 1);
    tick();
    check("boot UPDATE upd",    32'(update_o), 1);
    check("boot UPDATE ce",     32'(thresh_ce_o), 0);
    tick();
    check("boot IDLE busy",     32'(busy_o), 0);
    check("boot IDLE upd",      32'(update_o), 0);

    // Bring both thresholds to 256 for the servo test.
    write_thr(1'b1, 18'd256);
    write_thr(1'b0, 18'd256);
    run_to(10);
    trigger_i[0] = 1'b1;
    run_to(15);
    trigger_i[0] = 1'b0;
    run_to(32);
    check("cnt4 sat A", 32'(d4_count_a), 15);
    check("cnt4 sat B", 32'(d4_count_b), 15);
    check("cnt4 valid", 32'(d4_valid), 1);
    run_to(44);
    trigger_i[1] = 1'b1;

    // Period end at edge 64: A=20 (incl. edge 64), B=5.
    run_to(64);
    check("p1 valid",    32'(count_valid_o), 1);
    check("p1 count_a",  32'(count_a_o), 20);
    check("p1 count_b",  32'(count_b_o), 5);
    check("p1 thresh_a", 32'(thresh_a_o), 260);
    check("p1 thresh_b", 32'(thresh_b_o), 252);
    tick();
    check("p1 valid pulse", 32'(count_valid_o), 0);
    check("p1 LOAD_A thresh", 32'(thresh_o), 260);
    check("p1 LOAD_A ce",     32'(thresh_ce_o), 2);
    tick();
    check("p1 LOAD_B thresh", 32'(thresh_o), 252);
    check("p1 LOAD_B ce",     32'(thresh_ce_o), 1);
    tick();
    check("p1 UPDATE upd",    32'(update_o), 1);
    check("p1 UPDATE hold",   32'(thresh_o), 252);
    tick();
    check("p1 IDLE busy",     32'(busy_o), 0);

    // Period 2: A keeps triggering from edge 65 through 76 -> 12.
    run_to(69);
    write_thr(1'b1, 18'd246014);
    write_thr(1'b0, 18'd2);
    check("p2 wr thresh_a", 32'(thresh_a_o), 246014);
    run_to(76);
    trigger_i[1] = 1'b0;
    run_to(128);
    check("p2 count_a",    32'(count_a_o), 12);
    check("p2 count_b",    32'(count_b_o), 0);
    check("p2 sat hi A",   32'(thresh_a_o), 246016);
    check("p2 sat lo B",   32'(thresh_b_o), 0);

    // Period 3: servo disabled, counts still reported.
    run_to(140);
    trigger_i = 2'b11;
    run_to(143);
    trigger_i[1] = 1'b0;
    en_i = 1'b0;
    run_to(170);
    trigger_i[0] = 1'b0;
    run_to(192);
    check("p3 valid",    32'(count_valid_o), 1);
    check("p3 count_a",  32'(count_a_o), 3);
    check("p3 count_b",  32'(count_b_o), 30);
    check("p3 hold A",   32'(thresh_a_o), 246016);
    check("p3 hold B",   32'(thresh_b_o), 0);
    tick();
    check("p3 no load busy", 32'(busy_o), 0);
    check("p3 no load ce",   32'(thresh_ce_o), 0);
    en_i = 1'b1;

    // Period 4: direct write of A collides with period-end adjustment.
    run_to(200);
    trigger_i = 2'b11;
    run_to(215);
    trigger_i = 2'b00;
    run_to(255);
    write_thr(1'b1, 18'd1000);
    check("p4 count_a",   32'(count_a_o), 15);
    check("p4 count_b",   32'(count_b_o), 15);
    check("p4 wr wins A", 32'(thresh_a_o), 1000);
    check("p4 adj B",     32'(thresh_b_o), 4);
    tick();
    check("p4 LOAD_A thresh", 32'(thresh_o), 1000);
    tick();
    check("p4 LOAD_B thresh", 32'(thresh_o), 4);
    tick();
    check("p4 UPDATE upd",    32'(update_o), 1);
    tick();
    check("p4 IDLE busy",     32'(busy_o), 0);
    tick();
    check("p4 single seq busy", 32'(busy_o), 0);
    check("p4 single seq ce",   32'(thresh_ce_o), 0);

    // Direct write clamps to the ceiling.
    write_thr(1'b0, 18'd262143);
    check("clamp B", 32'(thresh_b_o), 246016);
    run_to(264);
    check("clamp LOAD_B thresh", 32'(thresh_o), 246016);
    run_to(269);

    // Write B during LOAD_B: old B loads now, new B in a second sequence.
    write_thr(1'b1, 18'd500);
    tick();
    check("wrB LOAD_A thresh", 32'(thresh_o), 500);
    tick();
    check("wrB LOAD_B old",    32'(thresh_o), 246016);
    check("wrB LOAD_B ce",     32'(thresh_ce_o), 1);
    write_thr(1'b0, 18'd777);
    check("wrB UPDATE upd",    32'(update_o), 1);
    check("wrB new reg",       32'(thresh_b_o), 777);
    tick();
    check("wrB IDLE pending busy", 32'(busy_o), 1);
    tick();
    check("wrB 2nd LOAD_A",    32'(thresh_o), 500);
    check("wrB 2nd LOAD_A ce", 32'(thresh_ce_o), 2);
    tick();
    check("wrB 2nd LOAD_B",    32'(thresh_o), 777);
    tick();
    check("wrB 2nd UPDATE",    32'(update_o), 1);
    tick();
    check("wrB 2nd IDLE busy", 32'(busy_o), 0);

    // Reset asserted mid-sequence (during LOAD_B).
    write_thr(1'b1, 18'd1234);
    tick();
    check("mid LOAD_A thresh", 32'(thresh_o), 1234);
    tick();
    check("mid LOAD_B ce",     32'(thresh_ce_o), 1);
    rst_i = 1'b1;
    #1;
    check("mid rst thresh_o", 32'(thresh_o), 0);
    check("mid rst ce",       32'(thresh_ce_o), 0);
    check("mid rst update",   32'(update_o), 0);
    check("mid rst thresh_a", 32'(thresh_a_o), INIT);
    check("mid rst thresh_b", 32'(thresh_b_o), INIT);
    check("mid rst count_a",  32'(count_a_o), 0);
    check("mid rst count_b",  32'(count_b_o), 0);
    check("mid rst valid",    32'(count_valid_o), 0);
    check("mid rst busy",     32'(busy_o), 1);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i  = 1'b0;
    edge_n = 0;
    tick();
    check("reboot LOAD_A thresh", 32'(thresh_o), INIT);
    check("reboot LOAD_A ce",     32'(thresh_ce_o), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
